// File: rtl/frame_write_arbiter_if.sv
// Bundle of the clear-control, two pixel requesters and the frame buffer
// write port. The arbiter takes the slave side; the environment (requesters,
// RAM) takes the master side.
//
// Handshake: a requester raises *_valid with x/y/color and holds them
// stable until *_ready is seen high; a pixel moves when valid && ready
// are both high at a rising clock edge. ready is combinational.
interface frame_write_arbiter_if #(
  parameter int ADDR_W = 20
);
  logic              clear_start;
  logic [2:0]        clear_color;
  logic              clear_busy;
  logic              clear_done;

  logic              a_valid;
  logic [9:0]        a_x;
  logic [8:0]        a_y;
  logic [2:0]        a_color;
  logic              a_ready;

  logic              b_valid;
  logic [9:0]        b_x;
  logic [8:0]        b_y;
  logic [2:0]        b_color;
  logic              b_ready;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [2:0]        ram_data;

  // FSM state for observation (0 = IDLE, 1 = CLEAR)
  logic              dbg_state;

  modport slave (
    input  clear_start, clear_color,
    input  a_valid, a_x, a_y, a_color,
    input  b_valid, b_x, b_y, b_color,
    output clear_busy, clear_done, a_ready, b_ready,
    output ram_we, ram_addr, ram_data, dbg_state
  );

  modport master (
    output clear_start, clear_color,
    output a_valid, a_x, a_y, a_color,
    output b_valid, b_x, b_y, b_color,
    input  clear_busy, clear_done, a_ready, b_ready,
    input  ram_we, ram_addr, ram_data, dbg_state
  );
endinterface

// File: rtl/frame_write_arbiter.sv
// Single write port owner for the frame buffer: round-robin arbitration
// between two pixel requesters plus a full-screen clear sequencer.
// All RAM-side outputs come straight from registers.
module frame_write_arbiter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 20
) (
  input logic                   Clk,
  input logic                   Reset,
  frame_write_arbiter_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;
  localparam logic [ADDR_W-1:0] H_RES_A   = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [2:0]        color_q, color_d;
  logic              ram_we_q, ram_we_d;
  // During a clear ram_addr_q doubles as the clear counter.
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [2:0]        ram_data_q, ram_data_d;
  logic              clear_done_q, clear_done_d;

  logic              arb_open;
  logic              grant_a, grant_b;
  logic              a_ready, b_ready;
  logic [9:0]        sel_x;
  logic [8:0]        sel_y;
  logic [2:0]        sel_color;
  logic              in_range;
  logic [ADDR_W-1:0] sel_addr;

  // Round-robin grant, ready generation and address of the granted pixel
  always_comb begin
    grant_a   = bus.a_valid && (!bus.b_valid || (last_grant_q == GRANT_B));
    grant_b   = bus.b_valid && !grant_a;
    arb_open  = (state_q == IDLE) && !bus.clear_start && !Reset;
    a_ready   = arb_open && grant_a;
    b_ready   = arb_open && grant_b;
    sel_x     = grant_b ? bus.b_x     : bus.a_x;
    sel_y     = grant_b ? bus.b_y     : bus.a_y;
    sel_color = grant_b ? bus.b_color : bus.a_color;
    in_range  = (32'(sel_x) < H_RES) && (32'(sel_y) < V_RES);
    sel_addr  = ADDR_W'(sel_y) * H_RES_A + ADDR_W'(sel_x);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    color_d      = color_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    clear_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.clear_start) begin
          // First clear write (address 0) goes out in the next cycle.
          state_d    = CLEAR;
          color_d    = bus.clear_color;
          ram_we_d   = 1'b1;
          ram_addr_d = '0;
          ram_data_d = bus.clear_color;
        end else if (a_ready || b_ready) begin
          last_grant_d = b_ready ? GRANT_B : GRANT_A;
          // Off-screen pixels are accepted but never written.
          if (in_range) begin
            ram_we_d   = 1'b1;
            ram_addr_d = sel_addr;
            ram_data_d = sel_color;
          end
        end
      end
      CLEAR: begin
        if (ram_addr_q == LAST_ADDR) begin
          state_d      = IDLE;
          clear_done_d = 1'b1;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = ram_addr_q + ADDR_W'(1);
          ram_data_d = color_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_B;
      color_q      <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      color_q      <= color_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign bus.a_ready    = a_ready;
  assign bus.b_ready    = b_ready;
  assign bus.clear_busy = (state_q == CLEAR);
  assign bus.clear_done = clear_done_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_data   = ram_data_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Bench for frame_write_arbiter. A short frame (640 x 16) keeps the clear
// runs to about 10k cycles each while leaving the line arithmetic intact.
module tb_frame_write_arbiter;

  localparam int H_RES  = 640;
  localparam int V_RES  = 16;
  localparam int ADDR_W = 20;
  localparam int N_PIX  = H_RES * V_RES;
  localparam int W      = ADDR_W + 3;

  logic Clk;
  logic Reset;

  frame_write_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  frame_write_arbiter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: {addr, data} of each expected RAM write, in order
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic       av;
    logic [9:0] ax;
    logic [8:0] ay;
    logic [2:0] ac;
    logic       bv;
    logic [9:0] bx;
    logic [8:0] by;
    logic [2:0] bc;
    logic       ea;
    logic       eb;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic av, input int ax, input int ay, input int ac,
                              input logic bv, input int bx, input int by, input int bc,
                              input logic ea, input logic eb);
    vec_t v;
    v.av = av; v.ax = 10'(ax); v.ay = 9'(ay); v.ac = 3'(ac);
    v.bv = bv; v.bx = 10'(bx); v.by = 9'(by); v.bc = 3'(bc);
    v.ea = ea; v.eb = eb;
    return v;
  endfunction

  function automatic logic on_screen(input logic [9:0] x, input logic [8:0] y);
    return (int'(x) < H_RES) && (int'(y) < V_RES);
  endfunction

  function automatic logic [W-1:0] wr_entry(input logic [9:0] x, input logic [8:0] y,
                                            input logic [2:0] c);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(int'(y) * H_RES + int'(x));
    return {a, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the falling edge: compares the RAM port with the scoreboard
  task automatic sb_check(input logic exp_we);
    logic [W-1:0] e;
    check("ram_we", 32'(bus.ram_we), 32'(exp_we));
    if (bus.ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL ram_write: got addr %0d data %0d expected no write",
                 bus.ram_addr, bus.ram_data);
      end else begin
        e = exp_q.pop_front();
        check("ram_write", 32'({bus.ram_addr, bus.ram_data}), 32'(e));
      end
    end
  endtask

  task automatic drive_idle();
    bus.a_valid = 1'b0; bus.a_x = '0; bus.a_y = '0; bus.a_color = '0;
    bus.b_valid = 1'b0; bus.b_x = '0; bus.b_y = '0; bus.b_color = '0;
  endtask

  // Full clear sequence; abort_at >= 0 asserts Reset while that write is on the port
  task automatic run_clear(input logic [2:0] color, input int abort_at, output logic next_we);
    next_we = 1'b0;
    bus.clear_start = 1'b1;
    bus.clear_color = color;
    @(negedge Clk);
    check("start_a_ready", 32'(bus.a_ready), 32'(0));
    check("start_b_ready", 32'(bus.b_ready), 32'(0));
    check("start_busy", 32'(bus.clear_busy), 32'(0));
    sb_check(1'b0);
    @(posedge Clk); #1;
    bus.clear_start = 1'b0;
    bus.clear_color = '0;
    for (int k = 0; k < N_PIX; k++) begin
      if (k == 5) begin
        bus.clear_start = 1'b1;
        bus.clear_color = ~color;
      end
      if (k == 6) bus.clear_start = 1'b0;
      if (k == abort_at) Reset = 1'b1;
      @(negedge Clk);
      exp_q.push_back({ADDR_W'(k), color});
      sb_check(1'b1);
      check("clear_busy", 32'(bus.clear_busy), 32'(1));
      check("clear_done_early", 32'(bus.clear_done), 32'(0));
      check("clear_a_ready", 32'(bus.a_ready), 32'(0));
      check("clear_b_ready", 32'(bus.b_ready), 32'(0));
      @(posedge Clk); #1;
      if (k == abort_at) begin
        @(negedge Clk);
        sb_check(1'b0);
        check("abort_busy", 32'(bus.clear_busy), 32'(0));
        check("abort_done", 32'(bus.clear_done), 32'(0));
        check("abort_state", 32'(bus.dbg_state), 32'(0));
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        sb_check(1'b0);
        check("abort_done_after", 32'(bus.clear_done), 32'(0));
        @(posedge Clk); #1;
        return;
      end
    end
    @(negedge Clk);
    sb_check(1'b0);
    check("end_busy", 32'(bus.clear_busy), 32'(0));
    check("end_done", 32'(bus.clear_done), 32'(1));
    check("end_state", 32'(bus.dbg_state), 32'(0));
    check("end_a_ready", 32'(bus.a_ready), 32'(bus.a_valid));
    if (bus.a_valid && on_screen(bus.a_x, bus.a_y)) begin
      exp_q.push_back(wr_entry(bus.a_x, bus.a_y, bus.a_color));
      next_we = 1'b1;
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    logic prev_we;
    logic nw;

    // Round-robin ordering, boundaries and dropped pixels; last grant starts at B
    vecs[0]  = mk(1, 10, 2, 5,    0, 0, 0, 0,      1, 0);
    vecs[1]  = mk(0, 0, 0, 0,     1, 639, 15, 7,   0, 1);
    vecs[2]  = mk(0, 0, 0, 0,     1, 640, 0, 1,    0, 1);
    vecs[3]  = mk(1, 1, 1, 1,     1, 2, 2, 2,      1, 0);
    vecs[4]  = mk(1, 3, 3, 3,     1, 2, 2, 2,      0, 1);
    vecs[5]  = mk(1, 3, 3, 3,     1, 4, 4, 4,      1, 0);
    vecs[6]  = mk(1, 5, 5, 5,     1, 4, 4, 4,      0, 1);
    vecs[7]  = mk(0, 0, 0, 0,     0, 0, 0, 0,      0, 0);
    vecs[8]  = mk(1, 0, 16, 6,    0, 0, 0, 0,      1, 0);
    vecs[9]  = mk(0, 0, 0, 0,     1, 0, 0, 4,      0, 1);
    vecs[10] = mk(1, 5, 0, 2,     1, 6, 0, 3,      1, 0);
    vecs[11] = mk(0, 0, 0, 0,     1, 6, 0, 3,      0, 1);

    Reset = 1'b1;
    bus.clear_start = 1'b0;
    bus.clear_color = '0;
    drive_idle();
    bus.a_valid = 1'b1; bus.a_x = 10'd10; bus.a_y = 9'd2; bus.a_color = 3'd5;

    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("rst_a_ready", 32'(bus.a_ready), 32'(0));
    check("rst_b_ready", 32'(bus.b_ready), 32'(0));
    check("rst_ram_we", 32'(bus.ram_we), 32'(0));
    check("rst_ram_addr", 32'(bus.ram_addr), 32'(0));
    check("rst_ram_data", 32'(bus.ram_data), 32'(0));
    check("rst_busy", 32'(bus.clear_busy), 32'(0));
    check("rst_done", 32'(bus.clear_done), 32'(0));
    @(posedge Clk); #1;
    Reset = 1'b0;

    prev_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.a_valid = vecs[i].av; bus.a_x = vecs[i].ax; bus.a_y = vecs[i].ay; bus.a_color = vecs[i].ac;
      bus.b_valid = vecs[i].bv; bus.b_x = vecs[i].bx; bus.b_y = vecs[i].by; bus.b_color = vecs[i].bc;
      @(negedge Clk);
      sb_check(prev_we);
      check($sformatf("vec%0d_a_ready", i), 32'(bus.a_ready), 32'(vecs[i].ea));
      check($sformatf("vec%0d_b_ready", i), 32'(bus.b_ready), 32'(vecs[i].eb));
      prev_we = 1'b0;
      if (vecs[i].ea && on_screen(vecs[i].ax, vecs[i].ay)) begin
        exp_q.push_back(wr_entry(vecs[i].ax, vecs[i].ay, vecs[i].ac));
        prev_we = 1'b1;
      end
      if (vecs[i].eb && on_screen(vecs[i].bx, vecs[i].by)) begin
        exp_q.push_back(wr_entry(vecs[i].bx, vecs[i].by, vecs[i].bc));
        prev_we = 1'b1;
      end
      @(posedge Clk); #1;
    end
    drive_idle();
    @(negedge Clk);
    sb_check(prev_we);
    @(posedge Clk); #1;

    // Clear colliding with a held A request; A is served right after clear_done
    bus.a_valid = 1'b1; bus.a_x = 10'd7; bus.a_y = 9'd7; bus.a_color = 3'd7;
    run_clear(3'd3, -1, nw);
    drive_idle();
    @(negedge Clk);
    sb_check(nw);
    check("post_clear_done", 32'(bus.clear_done), 32'(0));
    @(posedge Clk); #1;

    // Reset while write 1000 is on the port, then a full restart from address 0
    run_clear(3'd2, 1000, nw);
    run_clear(3'd4, -1, nw);
    @(negedge Clk);
    sb_check(nw);
    check("final_done", 32'(bus.clear_done), 32'(0));
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
